// File: rtl/sdio_cmd_resp_rx.sv
// SD/SDIO command-response receiver: waits out Ncr, catches the start bit, shifts in a
// 48-bit or 136-bit frame, checks CRC7 and the end bit, and drives the timeout counter.
module sdio_cmd_resp_rx #(
    parameter int unsigned NCR_MIN = 2
) (
    input  logic         sd_clk,
    input  logic         rst,
    input  logic         rx_start,
    input  logic         rx_abort,
    input  logic         resp_long,
    input  logic         resp_crc_chk,
    input  logic [7:0]   timeout_sel_in,
    input  logic         cmd_in,
    input  logic         timeout_event,
    output logic         timeout_cnt_en,
    output logic [7:0]   timeout_cnt_sel,
    output logic         rx_busy,
    output logic         resp_done,
    output logic         resp_timeout,
    output logic         resp_crc_err,
    output logic         resp_end_err,
    output logic [5:0]   resp_index,
    output logic [127:0] resp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] NCR_LOAD = 8'(NCR_MIN);

    state_t         state_q;
    logic           long_q;
    logic           chk_q;
    logic [7:0]     sel_q;
    logic [7:0]     ncr_q;
    logic [7:0]     bit_cnt_q;
    logic [6:0]     crc_q;
    logic [127:0]   shift_q;
    logic           en_q;
    logic           busy_q;
    logic           done_q;
    logic           timeout_q;
    logic           crc_err_q;
    logic           end_err_q;
    logic [5:0]     index_q;
    logic [127:0]   data_q;

    logic [127:0]   shift_d;
    logic           crc_en_s;
    logic [6:0]     crc_d;

    // One serial step of CRC7, G(x) = x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // bit_cnt_q equals the frame index of the bit being sampled in RECV.
    always_comb begin
        shift_d  = {shift_q[126:0], cmd_in};
        crc_en_s = (bit_cnt_q >= 8'd8) && (long_q ? (bit_cnt_q <= 8'd127) : 1'b1);
        crc_d    = crc_en_s ? crc7_step(crc_q, cmd_in) : crc_q;
    end

    // Receive FSM with all outputs registered.
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            long_q    <= 1'b0;
            chk_q     <= 1'b0;
            sel_q     <= 8'h00;
            ncr_q     <= 8'h00;
            bit_cnt_q <= 8'h00;
            crc_q     <= 7'h00;
            shift_q   <= 128'h0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            index_q   <= 6'h00;
            data_q    <= 128'h0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_start && !rx_abort) begin
                        state_q   <= S_WAIT;
                        long_q    <= resp_long;
                        chk_q     <= resp_crc_chk;
                        sel_q     <= timeout_sel_in;
                        ncr_q     <= NCR_LOAD;
                        en_q      <= 1'b1;
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                        crc_err_q <= 1'b0;
                        end_err_q <= 1'b0;
                        index_q   <= 6'h00;
                        data_q    <= 128'h0;
                    end
                end
                S_WAIT: begin
                    if (rx_abort) begin
                        state_q <= S_IDLE;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if ((ncr_q == 8'h00) && !cmd_in) begin
                        // Start bit takes priority over a coincident timeout.
                        state_q   <= S_RECV;
                        en_q      <= 1'b0;
                        bit_cnt_q <= long_q ? 8'd134 : 8'd46;
                        crc_q     <= 7'h00;
                        shift_q   <= 128'h0;
                    end else if (timeout_event) begin
                        state_q   <= S_DONE;
                        en_q      <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else if (ncr_q != 8'h00) begin
                        ncr_q <= ncr_q - 8'd1;
                    end
                end
                S_RECV: begin
                    if (rx_abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        shift_q   <= shift_d;
                        crc_q     <= crc_d;
                        bit_cnt_q <= bit_cnt_q - 8'd1;
                        if (bit_cnt_q == 8'h00) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            crc_err_q <= chk_q && (crc_q != shift_d[7:1]);
                            end_err_q <= !cmd_in;
                            index_q   <= long_q ? 6'h3F : shift_d[45:40];
                            data_q    <= long_q ? {shift_d[127:1], 1'b0}
                                                : {96'h0, shift_d[39:8]};
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign timeout_cnt_en  = en_q;
    assign timeout_cnt_sel = sel_q;
    assign rx_busy         = busy_q;
    assign resp_done       = done_q;
    assign resp_timeout    = timeout_q;
    assign resp_crc_err    = crc_err_q;
    assign resp_end_err    = end_err_q;
    assign resp_index      = index_q;
    assign resp_data       = data_q;

endmodule
